// File: rtl/pong_font_pkg.sv
// pong_font_pkg
//   Shared constants and types for the glyph text renderer: 5x7 glyph
//   geometry, character code constants and the stage-1 pipeline record
//   passed from the coordinate stage to the font-lookup stage.
package pong_font_pkg;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 7;

  localparam logic [5:0] CODE_A     = 6'd10;
  localparam logic [5:0] CODE_SPACE = 6'd63;

  // Everything the font stage needs about one raster pixel. The character
  // code and visibility are captured together with the coordinates so a
  // pixel always sees one consistent set of shadow values.
  typedef struct packed {
    logic       vis;     // shadow valid and not blanked by blink
    logic       in_box;  // pixel lies inside the string bounding box
    logic [5:0] code;    // character code under the pixel
    logic [2:0] row;     // font row 0..6 (only meaningful when in_box)
  } stage1_t;

endpackage

// File: rtl/glyph_font_rom.sv
// glyph_font_rom
//   Combinational 5x7 font. Looks up the 35-bit bitmap of a character code,
//   then returns the 5-bit pattern of one row.
//   Code map: 0-9 digits, 10-35 A-Z; every other code (36-63) is blank.
//   Pattern bit [4] is font column 0 (leftmost).
// Ports:
//   code     in  6  character code
//   row      in  3  font row, 0 = top; rows 7 and above read blank
//   pattern  out 5  lit columns of that row
module glyph_font_rom
  import pong_font_pkg::*;
(
  input  logic [5:0]         code,
  input  logic [2:0]         row,
  output logic [GLYPH_W-1:0] pattern
);

  // Bitmap is stored row 0 in the top five bits, row 6 in the bottom five.
  logic [GLYPH_W*GLYPH_H-1:0] glyph_s;

  // Character code to full glyph bitmap.
  always_comb begin
    glyph_s = 35'b0;
    case (code)
      6'd0:  glyph_s = 35'b01110_10001_10011_10101_11001_10001_01110;
      6'd1:  glyph_s = 35'b00100_01100_00100_00100_00100_00100_01110;
      6'd2:  glyph_s = 35'b01110_10001_00001_00010_00100_01000_11111;
      6'd3:  glyph_s = 35'b11111_00010_00100_00010_00001_10001_01110;
      6'd4:  glyph_s = 35'b00010_00110_01010_10010_11111_00010_00010;
      6'd5:  glyph_s = 35'b11111_10000_11110_00001_00001_10001_01110;
      6'd6:  glyph_s = 35'b00110_01000_10000_11110_10001_10001_01110;
      6'd7:  glyph_s = 35'b11111_00001_00010_00100_01000_01000_01000;
      6'd8:  glyph_s = 35'b01110_10001_10001_01110_10001_10001_01110;
      6'd9:  glyph_s = 35'b01110_10001_10001_01111_00001_00010_01100;
      6'd10: glyph_s = 35'b01110_10001_10001_11111_10001_10001_10001;
      6'd11: glyph_s = 35'b11110_10001_10001_11110_10001_10001_11110;
      6'd12: glyph_s = 35'b01110_10001_10000_10000_10000_10001_01110;
      6'd13: glyph_s = 35'b11100_10010_10001_10001_10001_10010_11100;
      6'd14: glyph_s = 35'b11111_10000_10000_11110_10000_10000_11111;
      6'd15: glyph_s = 35'b11111_10000_10000_11110_10000_10000_10000;
      6'd16: glyph_s = 35'b01110_10001_10000_10111_10001_10001_01111;
      6'd17: glyph_s = 35'b10001_10001_10001_11111_10001_10001_10001;
      6'd18: glyph_s = 35'b01110_00100_00100_00100_00100_00100_01110;
      6'd19: glyph_s = 35'b00111_00010_00010_00010_00010_10010_01100;
      6'd20: glyph_s = 35'b10001_10010_10100_11000_10100_10010_10001;
      6'd21: glyph_s = 35'b10000_10000_10000_10000_10000_10000_11111;
      6'd22: glyph_s = 35'b10001_11011_10101_10101_10001_10001_10001;
      6'd23: glyph_s = 35'b10001_10001_11001_10101_10011_10001_10001;
      6'd24: glyph_s = 35'b01110_10001_10001_10001_10001_10001_01110;
      6'd25: glyph_s = 35'b11110_10001_10001_11110_10000_10000_10000;
      6'd26: glyph_s = 35'b01110_10001_10001_10001_10101_10010_01101;
      6'd27: glyph_s = 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd28: glyph_s = 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd29: glyph_s = 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd30: glyph_s = 35'b10001_10001_10001_10001_10001_10001_01110;
      6'd31: glyph_s = 35'b10001_10001_10001_10001_10001_01010_00100;
      6'd32: glyph_s = 35'b10001_10001_10001_10101_10101_10101_01010;
      6'd33: glyph_s = 35'b10001_10001_01010_00100_01010_10001_10001;
      6'd34: glyph_s = 35'b10001_10001_10001_01010_00100_00100_00100;
      6'd35: glyph_s = 35'b11111_00001_00010_00100_01000_10000_11111;
      default: glyph_s = 35'b0;
    endcase
  end

  // Row select out of the glyph bitmap.
  always_comb begin
    pattern = 5'b0;
    case (row)
      3'd0: pattern = glyph_s[34:30];
      3'd1: pattern = glyph_s[29:25];
      3'd2: pattern = glyph_s[24:20];
      3'd3: pattern = glyph_s[19:15];
      3'd4: pattern = glyph_s[14:10];
      3'd5: pattern = glyph_s[9:5];
      3'd6: pattern = glyph_s[4:0];
      default: pattern = 5'b0;
    endcase
  end

endmodule

// File: rtl/glyph_text_render.sv
// glyph_text_render
//   Renders an N_CHARS string of 5x7 glyphs at a power-of-two scale at any
//   raster position. Position, string and blink mode are latched at the
//   frame_start pulse. Two register stages: coordinate/box stage, then font
//   lookup into the registered display flag.
// Ports:
//   clk          in  1             pixel clock
//   reset        in  1             synchronous, active-high
//   frame_start  in  1             one-cycle pulse per frame
//   start_x      in  COORD_W       left edge of the string
//   start_y      in  COORD_W       top edge of the string
//   x, y         in  COORD_W       current raster column / row
//   char_codes   in  6*N_CHARS     char 0 in bits [5:0], leftmost
//   blink_en     in  1             blink the string
//   display      out 1             pixel is a lit glyph pixel (2-cycle latency)
module glyph_text_render
  import pong_font_pkg::*;
#(
  parameter int N_CHARS      = 4,
  parameter int COORD_W      = 10,
  parameter int SCALE_LOG2   = 2,
  parameter int CELL_LOG2    = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [COORD_W-1:0]     start_x,
  input  logic [COORD_W-1:0]     start_y,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic [6*N_CHARS-1:0]   char_codes,
  input  logic                   blink_en,
  output logic                   display
);

  localparam int IDX_W   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CHAR_SH = CELL_LOG2 + SCALE_LOG2;
  localparam int BOX_W   = N_CHARS << CHAR_SH;
  localparam int BOX_H   = GLYPH_H << SCALE_LOG2;

  // Per-frame shadow state
  logic [COORD_W-1:0]   sx_r;
  logic [COORD_W-1:0]   sy_r;
  logic [6*N_CHARS-1:0] codes_r;
  logic                 blink_en_r;
  logic                 valid_r;
  logic [CNT_W-1:0]     blink_cnt_r;
  logic                 blink_phase_r;

  // Stage 1 signals
  logic [COORD_W:0]     dx_s;
  logic [COORD_W:0]     dy_s;
  logic [31:0]          dx_ext_s;
  logic [31:0]          dy_ext_s;
  logic                 in_box_s;
  logic [IDX_W-1:0]     char_idx_s;
  logic [5:0]           code_arr_s [N_CHARS];
  stage1_t              s1_next_s;
  stage1_t              s1_r;
  logic [CELL_LOG2-1:0] col_r;

  // Stage 2 signals
  logic [GLYPH_W-1:0]   pattern_s;
  logic [GLYPH_W-1:0]   shifted_s;
  logic                 col_in_glyph_s;
  logic                 pixel_on_s;

  // Shadow latch and blink counter, both advanced only by frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_r          <= '0;
      sy_r          <= '0;
      codes_r       <= {N_CHARS{CODE_SPACE}};
      blink_en_r    <= 1'b0;
      valid_r       <= 1'b0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else if (frame_start) begin
      sx_r       <= start_x;
      sy_r       <= start_y;
      codes_r    <= char_codes;
      blink_en_r <= blink_en;
      valid_r    <= 1'b1;
      if (blink_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Differences are one bit wider than the raster so a pixel left of or
  // above the string shows up as negative instead of wrapping into the box.
  assign dx_s     = {1'b0, x} - {1'b0, sx_r};
  assign dy_s     = {1'b0, y} - {1'b0, sy_r};
  assign dx_ext_s = 32'(dx_s[COORD_W-1:0]);
  assign dy_ext_s = 32'(dy_s[COORD_W-1:0]);

  assign in_box_s = ~dx_s[COORD_W] & ~dy_s[COORD_W]
                  & (dx_ext_s < 32'(BOX_W)) & (dy_ext_s < 32'(BOX_H));

  assign char_idx_s = dx_ext_s[CHAR_SH +: IDX_W];

  for (genvar g = 0; g < N_CHARS; g++) begin : g_codes
    assign code_arr_s[g] = codes_r[6*g +: 6];
  end

  // Stage-1 record; code and visibility come from the shadow values seen
  // by this pixel, so a frame_start mid-pipeline cannot mix two frames.
  always_comb begin
    s1_next_s        = '0;
    s1_next_s.vis    = valid_r & (~blink_en_r | blink_phase_r);
    s1_next_s.in_box = in_box_s;
    s1_next_s.row    = dy_ext_s[SCALE_LOG2 +: 3];
    if (in_box_s) begin
      s1_next_s.code = code_arr_s[char_idx_s];
    end else begin
      s1_next_s.code = CODE_SPACE;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r  <= '0;
      col_r <= '0;
    end else begin
      s1_r  <= s1_next_s;
      col_r <= dx_ext_s[SCALE_LOG2 +: CELL_LOG2];
    end
  end

  glyph_font_rom u_font (
    .code    (s1_r.code),
    .row     (s1_r.row),
    .pattern (pattern_s)
  );

  // Shift the wanted column up to the MSB, which is font column 0.
  assign shifted_s      = pattern_s << col_r;
  assign col_in_glyph_s = (32'(col_r) < 32'(GLYPH_W));
  assign pixel_on_s     = s1_r.vis & s1_r.in_box & col_in_glyph_s
                        & shifted_s[GLYPH_W-1];

  // Stage 2 register: the display output.
  always_ff @(posedge clk) begin
    if (reset) begin
      display <= 1'b0;
    end else begin
      display <= pixel_on_s;
    end
  end

endmodule
